// File: rtl/ratio_pulse_gen.sv
// Programmable pulse-train source: a phase accumulator adds step each RUN cycle,
// and every carry out becomes a one-cycle high pulse on sig_out. A run lasts
// for a programmed number of clk cycles (or until stop) and reports how many
// cycles elapsed and how many pulses were emitted.
module ratio_pulse_gen #(
   parameter int                ACC_W    = 16,
   parameter int                CNT_W    = 16,
   parameter logic [ACC_W-1:0]  STEP_MAX = ACC_W'(16'h8000)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [ACC_W-1:0] step,
   input  logic [CNT_W-1:0] window,
   output logic             sig_out,
   output logic             busy,
   output logic             done,
   output logic             step_sat,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] pulse_count
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] step_r;
   logic [CNT_W-1:0] window_r;

   logic [ACC_W:0]   sum;
   logic             carry;
   logic [CNT_W-1:0] cc_inc;
   logic [CNT_W-1:0] pc_inc;
   logic             win_end;

   // One accumulate step: carry is the pulse; counters saturate at all-ones.
   // window_r == 0 means free-run, so the count never terminates the run.
   always_comb begin
      sum     = {1'b0, acc} + {1'b0, step_r};
      carry   = sum[ACC_W];
      cc_inc  = (cycle_count == '1) ? cycle_count : cycle_count + 1'b1;
      pc_inc  = (pulse_count == '1 || !carry) ? pulse_count : pulse_count + 1'b1;
      win_end = (window_r != '0) && (cc_inc == window_r);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state: stop takes priority over the final window cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (stop || win_end) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: latch parameters on start, accumulate and count while running.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc         <= '0;
         step_r      <= '0;
         window_r    <= '0;
         step_sat    <= 1'b0;
         cycle_count <= '0;
         pulse_count <= '0;
         sig_out     <= 1'b0;
      end else begin
         sig_out <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  step_r      <= (step > STEP_MAX) ? STEP_MAX : step;
                  step_sat    <= (step > STEP_MAX);
                  window_r    <= window;
                  acc         <= '0;
                  cycle_count <= '0;
                  pulse_count <= '0;
               end
            end
            RUN: begin
               if (!stop) begin
                  acc         <= sum[ACC_W-1:0];
                  cycle_count <= cc_inc;
                  pulse_count <= pc_inc;
                  sig_out     <= carry;
               end
            end
            default: ;
         endcase
      end
   end

   // Status decoded straight from state; done is high for the single DONE cycle.
   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

endmodule
